as_gpio_checker: RTL and testbench
==================================

Name: as_gpio_checker

Overview:
- Synthesizable in-system self-check monitor on the core's GPIO write bus (cs/addr/data), beside as_top_mem.
- Compares each GPIO write against an ordered table of expected (address, data) entries, then reports PASS or FAIL with diagnostics.
- Adds a timeout watchdog and a strict/lenient address mode.
- Usable on silicon/FPGA as well as in simulation.

Parameters:
- DATA_W, default nr_gpios (as_pack): GPIO data width.
- ADDR_W, default gpio_addr_width (as_pack): GPIO address width.
- DEPTH, default 8: number of expected entries; power of two, at least 2.
- TIMEOUT_W, default 20: width of the idle-cycle watchdog counter.
- STRICT_ADDR, default 1: 1 means a write to an unexpected address is a failure; 0 means it is ignored.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- cs_i  in  1  GPIO write strobe, one cycle per write
- gpio_addr_i  in  ADDR_W  GPIO write address
- gpio_data_i  in  DATA_W  GPIO write data
- exp_we_i  in  1  expected-table write enable
- exp_idx_i  in  $clog2(DEPTH)  table index to write
- exp_addr_i  in  ADDR_W  expected address
- exp_data_i  in  DATA_W  expected data
- exp_len_i  in  $clog2(DEPTH)+1  number of valid entries (1..DEPTH); sampled on start_i
- timeout_i  in  TIMEOUT_W  maximum idle cycles between accepted writes; 0 disables the watchdog
- start_i  in  1  arm the checker (pulse)
- busy_o  out  1  checker is in RUN
- done_o  out  1  checker is in PASS or FAIL
- pass_o  out  1  all entries matched
- fail_o  out  1  mismatch or timeout occurred
- fail_code_o  out  2  00 none, 01 data mismatch, 10 unexpected address, 11 timeout
- match_cnt_o  out  $clog2(DEPTH)+1  number of entries matched so far
- fail_data_o  out  DATA_W  offending gpio_data_i, or 0 on timeout

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all outputs 0; index, counters and captured length cleared. The expected table is not reset; its contents are undefined until written.
- Table write:
  - Synchronous; accepted in any state.
  - Writes during RUN are allowed but the result is undefined; the bench must not do this.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE to RUN on start_i. Capture len = exp_len_i; len of 0 is treated as 1. Clear idx, match_cnt and the watchdog.
  - RUN, on cs_i with gpio_addr_i equal to exp_addr[idx] and gpio_data_i equal to exp_data[idx]: match_cnt and idx increment, watchdog clears. If idx+1 equals len, go to PASS on the next edge.
  - RUN, on cs_i with the address matching but the data differing: go to FAIL with code 01 and capture the data.
  - RUN, on cs_i with a different address:
    - STRICT_ADDR=1: go to FAIL with code 10 and capture the data.
    - STRICT_ADDR=0: ignore the write; the watchdog is not cleared.
  - RUN, no cs_i: the watchdog increments. When it reaches timeout_i (nonzero), go to FAIL with code 11 and fail_data_o = 0.
  - If cs_i and watchdog expiry fall in the same cycle, cs_i evaluation wins.
  - PASS/FAIL are sticky. start_i re-arms to RUN and clears pass_o, fail_o, fail_code_o and fail_data_o.
  - start_i during RUN restarts the check (idx = 0); any cs_i in that same cycle is ignored.
- Latency: the write is compared in the cycle cs_i is high. busy_o, done_o, pass_o, fail_o and match_cnt_o are registered, so they update one cycle later.
- Outputs:
  - busy_o = (state==RUN).
  - done_o = pass_o | fail_o.
  - pass_o and fail_o are never both 1.
- Width rules:
  - match_cnt_o saturates at len.
  - The watchdog saturates at all-ones and never wraps.
  - Comparisons are full-width, with no masking.
- Table storage: flops, with an asynchronous combinational read indexed by idx.

Decomposition:
- as_pack gains:
  - typedef chk_state_t (IDLE, RUN, PASS, FAIL);
  - typedef fail_code_t (2-bit enum FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT).
- One sub-module, as_chk_watchdog: a saturating TIMEOUT_W counter with clear/enable/limit inputs and an expired output.
- Table and FSM stay in as_gpio_checker.

Test Plan:
- Load {(4,130),(4,126)}, len=2, start; drive cs writes (4,130) then (4,126) -> pass_o=1 one cycle after the second write, match_cnt_o=2, fail_code_o=00.
- Same table; writes (4,130) then (4,125) -> fail_o=1, fail_code_o=01, fail_data_o=125, match_cnt_o=1.
- STRICT_ADDR=1; first write (5,130) -> FAIL, code 10, fail_data_o=130. STRICT_ADDR=0; writes (5,7),(4,130),(4,126) -> PASS, match_cnt_o=2.
- timeout_i=10; after one matching write, no cs for 10 cycles -> FAIL code 11 exactly 10 cycles after the last accept, fail_data_o=0. timeout_i=0 with no writes for 1000 cycles -> busy_o remains 1.
- Assert rst_i low mid-RUN after one match -> all outputs 0 immediately (asynchronously). After release, start and run the full sequence -> PASS, confirming the table is retained.
- After PASS, pulse start_i -> pass_o clears, busy_o=1. With len=8 (DEPTH), match all 8 entries -> PASS, match_cnt_o=8.

Source files
------------

// File: rtl/as_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// as_pack : shared GPIO widths and checker state/fail-code types
// Rev 1.0
// ---------------------------------------------------------------------------
package as_pack;

  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } chk_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_DATA    = 2'b01,
    FC_ADDR    = 2'b10,
    FC_TIMEOUT = 2'b11
  } fail_code_t;

endpackage
`default_nettype wire

// File: rtl/as_chk_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// as_chk_watchdog : saturating idle-cycle counter with programmable limit
// Rev 1.0
// ---------------------------------------------------------------------------
module as_chk_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Flags the idle cycle that would bring the count to the limit, so the
  // owning FSM leaves RUN on exactly the limit-th idle edge.
  assign expired = (limit != '0) && (count >= (limit - 1'b1));

endmodule
`default_nettype wire

// File: rtl/as_gpio_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// as_gpio_checker : compares GPIO writes against an ordered expected table
// Rev 1.0
// ---------------------------------------------------------------------------
module as_gpio_checker
  import as_pack::*;
#(
  parameter int DATA_W      = nr_gpios,
  parameter int ADDR_W      = gpio_addr_width,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_W   = 20,
  parameter bit STRICT_ADDR = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cs_i,
  input  logic [ADDR_W-1:0]        gpio_addr_i,
  input  logic [DATA_W-1:0]        gpio_data_i,
  input  logic                     exp_we_i,
  input  logic [$clog2(DEPTH)-1:0] exp_idx_i,
  input  logic [ADDR_W-1:0]        exp_addr_i,
  input  logic [DATA_W-1:0]        exp_data_i,
  input  logic [$clog2(DEPTH):0]   exp_len_i,
  input  logic [TIMEOUT_W-1:0]     timeout_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic [1:0]               fail_code_o,
  output logic [$clog2(DEPTH):0]   match_cnt_o,
  output logic [DATA_W-1:0]        fail_data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  logic [ADDR_W-1:0] exp_addr [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];

  chk_state_t        state;
  fail_code_t        code;
  logic [IDX_W-1:0]  idx;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  match_cnt;
  logic [DATA_W-1:0] fail_data;
  logic              busy, pass, fail;

  logic addr_hit, data_hit, accept, last_entry, wd_clr, wd_en, wd_expired;

  // Table is plain storage; it survives reset so a run can be re-armed.
  always_ff @(posedge clk_i) begin
    if (exp_we_i) begin
      exp_addr[exp_idx_i] <= exp_addr_i;
      exp_data[exp_idx_i] <= exp_data_i;
    end
  end

  assign addr_hit   = (gpio_addr_i == exp_addr[idx]);
  assign data_hit   = (gpio_data_i == exp_data[idx]);
  assign accept     = (state == RUN) && !start_i && cs_i && addr_hit && data_hit;
  assign last_entry = (({1'b0, idx} + 1'b1) == len);
  assign wd_clr     = start_i || accept;
  assign wd_en      = (state == RUN) && !cs_i;

  as_chk_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (timeout_i),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      code      <= FC_NONE;
      idx       <= '0;
      len       <= '0;
      match_cnt <= '0;
      fail_data <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else if (start_i) begin
      // Arming from any state, including a restart while RUN.
      state     <= RUN;
      code      <= FC_NONE;
      idx       <= '0;
      len       <= (exp_len_i == '0) ? LEN_W'(1) : exp_len_i;
      match_cnt <= '0;
      fail_data <= '0;
      busy      <= 1'b1;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else if (state == RUN) begin
      if (cs_i) begin
        if (addr_hit && data_hit) begin
          idx <= idx + 1'b1;
          if (match_cnt < len) match_cnt <= match_cnt + 1'b1;
          if (last_entry) begin
            state <= PASS;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end
        end else if (addr_hit || STRICT_ADDR) begin
          state     <= FAIL;
          code      <= addr_hit ? FC_DATA : FC_ADDR;
          fail_data <= gpio_data_i;
          busy      <= 1'b0;
          fail      <= 1'b1;
        end
      end else if (wd_expired) begin
        state     <= FAIL;
        code      <= FC_TIMEOUT;
        fail_data <= '0;
        busy      <= 1'b0;
        fail      <= 1'b1;
      end
    end
  end

  assign busy_o      = busy;
  assign pass_o      = pass;
  assign fail_o      = fail;
  assign done_o      = pass | fail;
  assign fail_code_o = code;
  assign match_cnt_o = match_cnt;
  assign fail_data_o = fail_data;

endmodule
`default_nettype wire

// File: tb/tb_as_gpio_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_as_gpio_checker : table-driven, scoreboarded bench for as_gpio_checker
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_as_gpio_checker;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 20;
  localparam int IW    = 3;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic [AW-1:0] gaddr = '0;
  logic [DW-1:0] gdata = '0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic [LW-1:0] exp_len = LW'(2);
  logic [TW-1:0] timeout = '0;
  logic          start = 1'b0;

  logic          s_busy, s_done, s_pass, s_fail, l_busy, l_done, l_pass, l_fail;
  logic [1:0]    s_code, l_code;
  logic [LW-1:0] s_cnt, l_cnt;
  logic [DW-1:0] s_fdata, l_fdata;

  always #5 clk = ~clk;

  as_gpio_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_W(TW), .STRICT_ADDR(1'b1)) u_strict (
    .clk_i(clk), .rst_i(rst_n), .cs_i(cs), .gpio_addr_i(gaddr), .gpio_data_i(gdata),
    .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_addr_i(exp_addr), .exp_data_i(exp_data),
    .exp_len_i(exp_len), .timeout_i(timeout), .start_i(start),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .fail_o(s_fail),
    .fail_code_o(s_code), .match_cnt_o(s_cnt), .fail_data_o(s_fdata));

  as_gpio_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_W(TW), .STRICT_ADDR(1'b0)) u_lenient (
    .clk_i(clk), .rst_i(rst_n), .cs_i(cs), .gpio_addr_i(gaddr), .gpio_data_i(gdata),
    .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_addr_i(exp_addr), .exp_data_i(exp_data),
    .exp_len_i(exp_len), .timeout_i(timeout), .start_i(start),
    .busy_o(l_busy), .done_o(l_done), .pass_o(l_pass), .fail_o(l_fail),
    .fail_code_o(l_code), .match_cnt_o(l_cnt), .fail_data_o(l_fdata));

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [1:0]    code;
    logic [LW-1:0] cnt;
    logic [DW-1:0] fdata;
  } obs_t;

  typedef struct {
    bit    inst;
    obs_t  exp;
    string name;
  } sb_t;

  typedef struct {
    bit            st;
    bit            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            inst;
    obs_t          exp;
    string         name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(input logic b, input logic p, input logic f,
                              input int c, input int cnt, input int fd);
    obs_t o;
    o.busy  = b;
    o.pass  = p;
    o.fail  = f;
    o.done  = p | f;
    o.code  = 2'(c);
    o.cnt   = LW'(cnt);
    o.fdata = DW'(fd);
    return o;
  endfunction

  function automatic obs_t observe(input bit inst);
    if (inst) return '{l_busy, l_done, l_pass, l_fail, l_code, l_cnt, l_fdata};
    return '{s_busy, s_done, s_pass, s_fail, s_code, s_cnt, s_fdata};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b pass=%b fail=%b code=%b cnt=%0d data=%0d, expected busy=%b done=%b pass=%b fail=%b code=%b cnt=%0d data=%0d",
               name, got.busy, got.done, got.pass, got.fail, got.code, got.cnt, got.fdata,
               exp.busy, exp.done, exp.pass, exp.fail, exp.code, exp.cnt, exp.fdata);
    end
  endtask

  task automatic step(input bit st, input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit inst, input obs_t e, input string nm);
    sb_t s;
    @(negedge clk);
    start = st;
    cs    = c;
    gaddr = a;
    gdata = d;
    sb_q.push_back('{inst, e, nm});
    @(posedge clk);
    #1;
    start = 1'b0;
    cs    = 1'b0;
    s = sb_q.pop_front();
    check(s.name, observe(s.inst), s.exp);
  endtask

  task automatic load(input int i, input int a, input int d);
    @(negedge clk);
    exp_we   = 1'b1;
    exp_idx  = IW'(i);
    exp_addr = AW'(a);
    exp_data = DW'(d);
    @(posedge clk);
    #1;
    exp_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    obs_t busy0;
    busy0 = mk(1, 0, 0, 0, 0, 0);

    vecs[0]  = '{1, 0, 0, 0,   0, mk(1, 0, 0, 0, 0, 0),   "match_start"};
    vecs[1]  = '{0, 1, 4, 130, 0, mk(1, 0, 0, 0, 1, 0),   "match_first"};
    vecs[2]  = '{0, 1, 4, 126, 0, mk(0, 1, 0, 0, 2, 0),   "match_pass"};
    vecs[3]  = '{0, 0, 0, 0,   0, mk(0, 1, 0, 0, 2, 0),   "pass_sticky"};
    vecs[4]  = '{1, 0, 0, 0,   0, mk(1, 0, 0, 0, 0, 0),   "data_start"};
    vecs[5]  = '{0, 1, 4, 130, 0, mk(1, 0, 0, 0, 1, 0),   "data_first"};
    vecs[6]  = '{0, 1, 4, 125, 0, mk(0, 0, 1, 1, 1, 125), "data_mismatch"};
    vecs[7]  = '{1, 0, 0, 0,   0, mk(1, 0, 0, 0, 0, 0),   "strict_start"};
    vecs[8]  = '{0, 1, 5, 130, 0, mk(0, 0, 1, 2, 0, 130), "strict_bad_addr"};
    vecs[9]  = '{1, 0, 0, 0,   1, mk(1, 0, 0, 0, 0, 0),   "lenient_start"};
    vecs[10] = '{0, 1, 5, 7,   1, mk(1, 0, 0, 0, 0, 0),   "lenient_ignore"};
    vecs[11] = '{0, 1, 4, 130, 1, mk(1, 0, 0, 0, 1, 0),   "lenient_first"};
    vecs[12] = '{0, 1, 4, 126, 1, mk(0, 1, 0, 0, 2, 0),   "lenient_pass"};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", observe(0), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    load(0, 4, 130);
    load(1, 4, 126);
    exp_len = LW'(2);
    timeout = '0;
    for (int i = 0; i < 13; i++)
      step(vecs[i].st, vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].inst, vecs[i].exp, vecs[i].name);

    // Watchdog: fail exactly ten idle edges after the last accepted write.
    timeout = TW'(10);
    step(1, 0, 0, 0, 0, busy0, "to_start");
    step(0, 1, 4, 130, 0, mk(1, 0, 0, 0, 1, 0), "to_accept");
    for (int k = 1; k <= 9; k++)
      step(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0), $sformatf("to_idle%0d", k));
    step(0, 0, 0, 0, 0, mk(0, 0, 1, 3, 1, 0), "to_expire");

    timeout = '0;
    step(1, 0, 0, 0, 0, busy0, "wd_off_start");
    repeat (1000) @(posedge clk);
    step(0, 0, 0, 0, 0, busy0, "wd_off_still_busy");

    // Asynchronous reset in the middle of a cycle, then the retained table.
    step(1, 0, 0, 0, 0, busy0, "rst_start");
    step(0, 1, 4, 130, 0, mk(1, 0, 0, 0, 1, 0), "rst_first");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_strict", observe(0), mk(0, 0, 0, 0, 0, 0));
    check("async_reset_lenient", observe(1), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, busy0, "retain_start");
    step(0, 1, 4, 130, 0, mk(1, 0, 0, 0, 1, 0), "retain_first");
    step(0, 1, 4, 126, 0, mk(0, 1, 0, 0, 2, 0), "retain_pass");

    // Full-depth table, re-armed from PASS.
    for (int i = 0; i < DEPTH; i++) load(i, i, i * 29 + 3);
    exp_len = LW'(DEPTH);
    step(1, 0, 0, 0, 0, busy0, "rearm_from_pass");
    for (int i = 0; i < DEPTH - 1; i++)
      step(0, 1, AW'(i), DW'(i * 29 + 3), 0, mk(1, 0, 0, 0, i + 1, 0), $sformatf("depth_w%0d", i));
    step(0, 1, AW'(DEPTH - 1), DW'((DEPTH - 1) * 29 + 3), 0, mk(0, 1, 0, 0, DEPTH, 0), "depth_pass");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
